// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler: sequences MUL/DIV units and owns HI/LO.
// Optional: define MULDIV_DIV0_FAST_EN to retire divide-by-zero at accept.
module muldiv_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic        flush,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_complete,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DIV
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic accept;
  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;

  always_comb begin
    is_mul  = (req_op == OP_MULT) || (req_op == OP_MULTU);
    is_div  = (req_op == OP_DIV) || (req_op == OP_DIVU);
    is_mthi = (req_op == OP_MTHI);
    is_mtlo = (req_op == OP_MTLO);
  end

  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = req_op;
          x_d  = req_x;
          y_d  = req_y;
          unique case (1'b1)
            is_mthi: begin
              hi_d   = req_x;
              done_d = 1'b1;
            end
            is_mtlo: begin
              lo_d   = req_x;
              done_d = 1'b1;
            end
            is_mul: state_d = MUL1;
            is_div: begin
`ifdef MULDIV_DIV0_FAST_EN
              if (req_y == 32'h0) begin
                lo_d   = 32'hFFFF_FFFF;
                hi_d   = req_x;
                done_d = 1'b1;
              end else begin
                state_d = DIV;
              end
`else
              state_d = DIV;
`endif
            end
            default: ;
          endcase
        end
      end
      MUL1: begin
        state_d = flush ? IDLE : MUL2;
      end
      MUL2: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = mul_result[63:32];
          lo_d   = mul_result[31:0];
          done_d = 1'b1;
        end
      end
      DIV: begin
        // flush beats a coincident completion
        if (flush) begin
          state_d = IDLE;
        end else if (div_complete) begin
          state_d = IDLE;
          lo_d    = div_s;
          hi_d    = div_r;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      x_q     <= 32'h0;
      y_q     <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // op_q resets to the MULT code, so signedness is qualified by state
  assign mul_signed = ((state_q == MUL1) || (state_q == MUL2))
                      && (op_q == OP_MULT);
  assign div_signed = (state_q == DIV) && (op_q == OP_DIV);
  assign div_start  = (state_q == DIV);
  assign div_x      = x_q;
  assign div_y      = y_q;
  assign mul_x      = x_q;
  assign mul_y      = y_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule
